// File: rtl/pwm_capture_pkg.sv
// Shared types and sizing helpers for the PWM capture block.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_e;

  // Measurement counters are one bit wider than the generator counter
  function automatic int mw_of(input int ctr_len);
    return ctr_len + 1;
  endfunction

  function automatic int sat_max(input int mw);
    return (1 << mw) - 1;
  endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer for an asynchronous line plus rising-edge detect.
module pwm_capture_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM line; flags a stuck line on timeout.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CTR_LEN = 8,
  parameter int TIMEOUT = (1 << (CTR_LEN + 1)) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CTR_LEN:0] duty,
  output logic [CTR_LEN:0] period,
  output logic             valid,
  output logic             stuck
);

  localparam int          MW   = mw_of(CTR_LEN);
  localparam logic [MW-1:0] MAXV = MW'(sat_max(MW));
  localparam logic [MW-1:0] TO   = MW'(TIMEOUT);
  localparam logic [MW-1:0] ONE  = MW'(1);

  logic s2, rise;

  pwm_capture_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (s2),
    .rise  (rise)
  );

  state_e        state_q, state_d;
  logic [MW-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
  logic [MW-1:0] duty_q, duty_d, period_q, period_d;
  logic          valid_q, valid_d, stuck_q, stuck_d;
  logic [MW-1:0] pcnt_inc, hcnt_inc;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    duty_d   = duty_q;
    period_d = period_q;
    stuck_d  = stuck_q;
    valid_d  = 1'b0;
    pcnt_inc = (pcnt_q == MAXV) ? pcnt_q : pcnt_q + ONE;
    hcnt_inc = (s2 && hcnt_q != MAXV) ? hcnt_q + ONE : hcnt_q;

    case (state_q)
      IDLE, MEASURE: begin
        // A rise in the timeout cycle wins over stuck detection
        if (rise) begin
          if (state_q == MEASURE) begin
            duty_d   = hcnt_q;
            period_d = pcnt_q;
            valid_d  = 1'b1;
            stuck_d  = 1'b0;
          end
          pcnt_d  = ONE;
          hcnt_d  = ONE;
          state_d = MEASURE;
        end else if (pcnt_q >= TO) begin
          state_d  = STUCK;
          stuck_d  = 1'b1;
          period_d = '0;
          duty_d   = s2 ? MAXV : '0;
          valid_d  = 1'b1;
        end else begin
          pcnt_d = pcnt_inc;
          hcnt_d = hcnt_inc;
        end
      end
      STUCK: begin
        // stuck stays asserted until the first full period after recovery
        if (rise) begin
          pcnt_d  = ONE;
          hcnt_d  = ONE;
          state_d = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench: a PWM generator drives pwm_in; expected reports are queued, a monitor checks each valid.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [8:0] duty, period;
  logic       valid, stuck;

  pwm_capture #(.CTR_LEN(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .stuck  (stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] duty;
    logic [8:0] period;
    logic       stuck;
    int         exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   ctr = 0;
  int   cmp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int d, input int p, input bit s, input int ec);
    exp_t e;
    e.duty = 9'(d); e.period = 9'(p); e.stuck = s; e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  task automatic set_line(input logic v);
    if (v && !pwm_in) last_rise = cyc + 1;
    pwm_in = v;
  endtask

  task automatic run_gen(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_line(ctr < cmp);
      ctr = (ctr + 1) % 256;
    end
  endtask

  task automatic drive_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_line(v);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (duty !== 9'd0 || period !== 9'd0 || valid !== 1'b0 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL %s: duty=%0d period=%0d valid=%b stuck=%b, required all 0",
               tag, duty, period, valid, stuck);
    end
  endtask

  // Monitor: pops one expectation per valid strobe
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && valid === 1'b1) begin
        checks++;
        if (prev_v) begin
          errors++;
          $display("FAIL valid_back_to_back at cyc %0d", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid at cyc %0d: duty=%0d period=%0d stuck=%b",
                   cyc, duty, period, stuck);
        end else begin
          e = sb.pop_front();
          if (duty !== e.duty || period !== e.period || stuck !== e.stuck) begin
            errors++;
            $display("FAIL report at cyc %0d: got duty=%0d period=%0d stuck=%b, required duty=%0d period=%0d stuck=%b",
                     cyc, duty, period, stuck, e.duty, e.period, e.stuck);
          end
          if (e.exp_cyc >= 0) begin
            checks++;
            if (cyc != e.exp_cyc) begin
              errors++;
              $display("FAIL stuck_timing: valid at cyc %0d, required cyc %0d", cyc, e.exp_cyc);
            end
          end
        end
      end
      prev_v = (rst === 1'b1) ? valid : 1'b0;
    end
  end

  initial begin
    rst = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b1;

    // compare=128: first rise silent, then 128/256
    for (int i = 0; i < 4; i++) push(128, 256, 0, -1);
    cmp = 128; ctr = 0;
    run_gen(5 * 256);

    // switch to 30 on a period boundary
    push(128, 256, 0, -1);
    for (int i = 0; i < 3; i++) push(30, 256, 0, -1);
    cmp = 30; ctr = 0;
    run_gen(4 * 256);

    // line held low: one stuck report 511 cycles after the last registered rise
    push(0, 0, 1, last_rise + 513);
    cmp = 0; ctr = 0;
    run_gen(600);

    // compare=255: recovery rise silent, then 255/256
    for (int i = 0; i < 3; i++) push(255, 256, 0, -1);
    cmp = 255; ctr = 0;
    run_gen(4 * 256);

    // forced high: closing rise completes a period, then stuck high
    push(255, 256, 0, -1);
    drive_level(1'b1, 1);
    push(511, 0, 1, last_rise + 513);
    drive_level(1'b1, 599);

    // restart at 64: first rise recovers silently, stuck holds until the second
    push(64, 256, 0, -1);
    push(64, 256, 0, -1);
    cmp = 64; ctr = 0;
    run_gen(256 + 10);
    checks++;
    if (stuck !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold_after_recovery: stuck=%b, required 1", stuck);
    end
    run_gen(3 * 256 - 10);

    // async reset mid-period
    push(64, 256, 0, -1);
    run_gen(100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    push(64, 256, 0, -1);
    push(64, 256, 0, -1);
    run_gen(156 + 512 + 20);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_valids: %0d outstanding, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the pwm generator: measures an incoming PWM waveform and reports high time and period in clk cycles.
- Output duty equals the generator's compare value when both share the same CTR_LEN and clock.
- Detects a stuck-high or stuck-low line via a period timeout.
- Sits between an external/looped-back PWM line and register/control logic.

Parameters:
- CTR_LEN, 8, generator counter width; measurement counters are CTR_LEN+1 bits wide (MW).
- TIMEOUT, 2^(CTR_LEN+1)-1, cycles since the last rising edge before the line is declared stuck; must be ≤ 2^MW-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- pwm_in  input  1  asynchronous PWM line.
- duty  output  MW  high cycles in the last complete period.
- period  output  MW  cycles between the last two rising edges.
- valid  output  1  one-cycle strobe; duty/period/stuck updated this cycle.
- stuck  output  1  line has had no rising edge for TIMEOUT cycles.

Behaviour:
- Reset (rst=0, async): duty=0, period=0, valid=0, stuck=0, state=IDLE, counters=0, synchronizer flops=0.
- Input path:
  - 2-flop synchronizer s1→s2, plus prev=s2 delayed one cycle.
  - rise = s2 & ~prev.
  - Rise detected 2 edges after pwm_in is first sampled high; outputs register on the 3rd edge.
- Counters pcnt and hcnt (MW bits) saturate at 2^MW-1 and never wrap.
- States:
  - IDLE (first edge not yet seen):
    - rise: pcnt←1, hcnt←1, go MEASURE, no valid.
    - pcnt reaches TIMEOUT: go STUCK.
  - MEASURE, on rise:
    - duty←hcnt, period←pcnt, valid=1, stuck=0.
    - pcnt←1, hcnt←1.
  - MEASURE, otherwise:
    - pcnt++; hcnt += s2.
    - If pcnt==TIMEOUT: go STUCK.
  - Entry to STUCK (single cycle):
    - stuck←1, period←0, duty←(s2 ? 2^MW-1 : 0), valid=1 once.
    - Counters hold.
  - STUCK, on rise:
    - pcnt←1, hcnt←1, go MEASURE.
    - stuck stays 1 until the first complete period after recovery.
    - No valid at the recovery edge.
- Counting convention: cycle of rise counts as 1. A 256-cycle period with 128 high samples reports period=256, duty=128.
- Outputs are registered and hold between valid strobes; valid is never high two consecutive cycles.
- Simultaneous rise and timeout in the same cycle: rise wins, no STUCK entry.
- Glitches shorter than one clk may be missed; no debounce is required.
- Reset mid-measurement: everything clears and the first edge after reset is discarded (IDLE).

Decomposition:
- Shared package: MW as a function of CTR_LEN, the state encoding (IDLE, MEASURE, STUCK), and the saturation-max constant.
- Natural sub-module: sync_edge (2-flop synchronizer plus rise detect, async active-low reset).
- Counters and FSM stay in pwm_capture.

Test Plan:
- pwm generator CTR_LEN=8, compare=128, looped to pwm_in:
  - No valid on the first rise.
  - Every subsequent valid shows duty=128, period=256; stuck=0.
- Switch compare 128→30 mid-run:
  - At most one transitional valid with intermediate duty.
  - All following valids show duty=30, period=256.
- compare=0 (line held low), after a prior good period:
  - Exactly 511 cycles after the last rise: single valid with stuck=1, duty=0, period=0.
  - No further valids.
- compare=255:
  - duty=255, period=256.
- Force pwm_in high for 600 cycles:
  - stuck=1 with duty=511.
  - Then restart PWM at compare=64: stuck clears on the second rise, with duty=64, period=256.
- Assert rst for 1 cycle mid-period:
  - All outputs are 0 immediately (async).
  - First post-reset rise produces no valid.
  - Second rise produces correct values.
